// File: rtl/frame_buf_rd_sched.sv
// frame_buf_rd_sched: read-side scheduler for the five-entry one-hot frame
// buffer ring. Each reader's vsync rise queues a request; a round-robin
// arbiter serializes the three readers through an IDLE/SEL/UPD FSM that hands
// the reader the last completed write buffer, or keeps its previous buffer
// when the candidate is not one-hot or is currently being written.
// Optional build macro FB_RD_SCHED_STAT_EN adds rd_repeat_cnt, three 8-bit
// saturating counters of fallback commits (reader i in bits [8i+7:8i]).
module frame_buf_rd_sched #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]  BUF_SIZE  = ADDR_W'(32'h0080_0000)
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [2:0]        rd_vs,
  input  logic [4:0]        wr_done_point,
  input  logic [4:0]        wr_current_point,
  output logic [4:0]        rd0_curr_point,
  output logic [4:0]        rd1_curr_point,
  output logic [4:0]        rd2_curr_point,
  output logic [ADDR_W-1:0] rd0_base_addr,
  output logic [ADDR_W-1:0] rd1_base_addr,
  output logic [ADDR_W-1:0] rd2_base_addr,
  output logic [2:0]        rd_update,
  output logic [2:0]        rd_repeat,
`ifdef FB_RD_SCHED_STAT_EN
  output logic [23:0]       rd_repeat_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_UPD} state_t;

  state_t                  state_q;
  logic [2:0]              rd_vs_q;
  logic [2:0]              pending_q;
  logic [2:0]              rise;
  logic [2:0]              clr;
  logic [1:0]              rr_last_q;
  logic [1:0]              gi_q;
  logic [1:0]              gi_d;
  logic [1:0]              rr_c;
  logic                    rr_found;
  logic [4:0]              cand_q;
  logic [2:0][4:0]         point_q;
  logic [2:0][ADDR_W-1:0]  base_q;
  logic [2:0]              upd_q;
  logic [2:0]              rep_q;
  logic                    busy_q;
  logic                    ok;
  logic [4:0]              new_pt;
  logic [2:0]              new_idx;
  logic [ADDR_W-1:0]       new_base;

  // A request is a 0->1 transition of a reader's vsync level.
  assign rise = rd_vs & ~rd_vs_q;
  // The reader being committed in SEL drops its pending flag.
  assign clr  = (state_q == S_SEL) ? (3'b001 << gi_q) : 3'b000;

  // Round-robin pick: scan readers starting after the last one served.
  always_comb begin
    gi_d     = 2'd0;
    rr_found = 1'b0;
    rr_c     = rr_last_q;
    for (int k = 0; k < 3; k++) begin
      rr_c = (rr_c == 2'd2) ? 2'd0 : rr_c + 2'd1;
      if (!rr_found && pending_q[rr_c]) begin
        gi_d     = rr_c;
        rr_found = 1'b1;
      end
    end
  end

  // Candidate check and the resulting point/base for the granted reader.
  always_comb begin
    ok = (cand_q != 5'd0) && ((cand_q & (cand_q - 5'd1)) == 5'd0) &&
         ((cand_q & wr_current_point) == 5'd0);
    new_pt  = ok ? cand_q : point_q[gi_q];
    new_idx = 3'd0;
    for (int b = 0; b < 5; b++) begin
      if (new_pt[b]) new_idx = 3'(b);
    end
    new_base = BASE_ADDR + ADDR_W'(new_idx) * BUF_SIZE;
  end

  // Edge detector and pending flags; a fresh rise wins over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rd_vs_q   <= 3'b000;
      pending_q <= 3'b000;
    end else begin
      rd_vs_q   <= rd_vs;
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  // Scheduler FSM with registered assignments, pulses and busy flag.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= S_IDLE;
      rr_last_q <= 2'd2;
      gi_q      <= 2'd0;
      cand_q    <= 5'd0;
      point_q   <= '0;
      base_q    <= {3{BASE_ADDR}};
      upd_q     <= 3'b000;
      rep_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      upd_q <= 3'b000;
      rep_q <= 3'b000;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            state_q <= S_SEL;
            gi_q    <= gi_d;
            cand_q  <= wr_done_point;
            busy_q  <= 1'b1;
          end
        end
        S_SEL: begin
          state_q       <= S_UPD;
          point_q[gi_q] <= new_pt;
          base_q[gi_q]  <= new_base;
          upd_q         <= 3'b001 << gi_q;
          rep_q         <= ok ? 3'b000 : (3'b001 << gi_q);
          rr_last_q     <= gi_q;
        end
        S_UPD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FB_RD_SCHED_STAT_EN
  logic [2:0][7:0] cnt_q;

  // Saturating count of fallback commits per reader.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rep_q[i] && cnt_q[i] != 8'hff) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign rd_repeat_cnt = cnt_q;
`endif

  assign rd0_curr_point = point_q[0];
  assign rd1_curr_point = point_q[1];
  assign rd2_curr_point = point_q[2];
  assign rd0_base_addr  = base_q[0];
  assign rd1_base_addr  = base_q[1];
  assign rd2_base_addr  = base_q[2];
  assign rd_update      = upd_q;
  assign rd_repeat      = rep_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_frame_buf_rd_sched.sv
// Testbench for frame_buf_rd_sched: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the scheduler.
module tb_frame_buf_rd_sched;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0080_0000;

  logic        wclk;
  logic        wrst_n;
  logic [2:0]  rd_vs;
  logic [4:0]  wr_done_point;
  logic [4:0]  wr_current_point;
  logic [4:0]  rd0_curr_point, rd1_curr_point, rd2_curr_point;
  logic [31:0] rd0_base_addr, rd1_base_addr, rd2_base_addr;
  logic [2:0]  rd_update, rd_repeat;
  logic        busy;
`ifdef FB_RD_SCHED_STAT_EN
  logic [23:0] rd_repeat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  frame_buf_rd_sched dut (
    .wclk             (wclk),
    .wrst_n           (wrst_n),
    .rd_vs            (rd_vs),
    .wr_done_point    (wr_done_point),
    .wr_current_point (wr_current_point),
    .rd0_curr_point   (rd0_curr_point),
    .rd1_curr_point   (rd1_curr_point),
    .rd2_curr_point   (rd2_curr_point),
    .rd0_base_addr    (rd0_base_addr),
    .rd1_base_addr    (rd1_base_addr),
    .rd2_base_addr    (rd2_base_addr),
    .rd_update        (rd_update),
    .rd_repeat        (rd_repeat),
`ifdef FB_RD_SCHED_STAT_EN
    .rd_repeat_cnt    (rd_repeat_cnt),
`endif
    .busy             (busy)
  );

  // Clock and reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Reference model: requests are a set of pending readers, served one at a
  // time; each service takes three cycles (grant, commit, recover).
  logic [4:0]  m_pt   [3];
  logic [31:0] m_base [3];
  logic [2:0]  m_pend, m_vsprev, m_upd, m_rep;
  logic [4:0]  m_cand;
  int          m_phase, m_last, m_g;
  int          m_cnt  [3];

  logic [14:0] d_pts, e_pts;
  logic [95:0] d_bases, e_bases;
  logic [6:0]  d_flags, e_flags;
  assign d_pts   = {rd2_curr_point, rd1_curr_point, rd0_curr_point};
  assign e_pts   = {m_pt[2], m_pt[1], m_pt[0]};
  assign d_bases = {rd2_base_addr, rd1_base_addr, rd0_base_addr};
  assign e_bases = {m_base[2], m_base[1], m_base[0]};
  assign d_flags = {busy, rd_repeat, rd_update};
  assign e_flags = {(m_phase != 0), m_rep, m_upd};

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pt[i] = 5'd0; m_base[i] = BASE; m_cnt[i] = 0;
    end
    m_pend = 0; m_vsprev = 0; m_upd = 0; m_rep = 0; m_cand = 0;
    m_phase = 0; m_last = 2; m_g = 0;
  endtask

  task automatic model_edge();
    logic ok;
    logic [4:0] np;
    bit found;
    if (!wrst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++)
      if (m_rep[i] && m_cnt[i] < 255) m_cnt[i]++;
    m_upd = 0; m_rep = 0;
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (!found && m_pend[c]) begin m_g = c; found = 1; end
        end
        m_cand = wr_done_point;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      ok = ($countones(m_cand) == 1) && ((m_cand & wr_current_point) == 0);
      np = ok ? m_cand : m_pt[m_g];
      m_pt[m_g] = np;
      m_base[m_g] = BASE + 32'($clog2(np)) * SIZE;
      m_upd[m_g] = 1'b1;
      m_rep[m_g] = !ok;
      m_pend[m_g] = 1'b0;
      m_last = m_g;
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_pend = m_pend | (rd_vs & ~m_vsprev);
    m_vsprev = rd_vs;
  endtask

  // Driver tasks
  task automatic step();
    @(posedge wclk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    rd_vs = 3'b000;
    model_reset();
    step();
    step();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; rd_vs = 0; wr_done_point = 0; wr_current_point = 0;
    model_reset();
    step();
    checks++;
    if (d_pts !== 15'd0) begin errors++; $display("FAIL reset_points got %h exp %h", d_pts, 15'd0); end
    checks++;
    if (d_bases !== {3{BASE}}) begin errors++; $display("FAIL reset_bases got %h exp %h", d_bases, {3{BASE}}); end
    checks++;
    if (d_flags !== 7'd0) begin errors++; $display("FAIL reset_flags got %b exp %b", d_flags, 7'd0); end
    wrst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    wr_done_point = 5'b00100; wr_current_point = 5'b00001;
    rd_vs = 3'b001;
    step();            // k: pending
    step();            // k+1: SEL
    checks++;
    if (rd_update !== 3'b000) begin errors++; $display("FAIL single_early_update got %b exp %b", rd_update, 3'b000); end
    rd_vs = 3'b000;
    step();            // k+2: commit
    checks++;
    if (rd0_curr_point !== 5'b00100) begin errors++; $display("FAIL single_point got %b exp %b", rd0_curr_point, 5'b00100); end
    checks++;
    if (rd0_base_addr !== 32'h0100_0000) begin errors++; $display("FAIL single_base got %h exp %h", rd0_base_addr, 32'h0100_0000); end
    checks++;
    if ({rd_repeat, rd_update} !== 6'b000_001) begin errors++; $display("FAIL single_pulse got %b exp %b", {rd_repeat, rd_update}, 6'b000_001); end
    step();            // k+3
    checks++;
    if (d_flags !== 7'd0) begin errors++; $display("FAIL single_idle got %b exp %b", d_flags, 7'd0); end
  endtask

  task automatic test_all_three();
    logic [2:0] exp_u;
    do_reset();
    wr_done_point = 5'b01000; wr_current_point = 5'b00000;
    rd_vs = 3'b111;
    for (int s = 0; s <= 9; s++) begin
      step();
      exp_u = (s == 2) ? 3'b001 : (s == 5) ? 3'b010 : (s == 8) ? 3'b100 : 3'b000;
      checks++;
      if (rd_update !== exp_u) begin errors++; $display("FAIL all3_update_c%0d got %b exp %b", s, rd_update, exp_u); end
      checks++;
      if (d_flags !== e_flags) begin errors++; $display("FAIL all3_model_c%0d got %b exp %b", s, d_flags, e_flags); end
    end
    checks++;
    if (d_pts !== {3{5'b01000}}) begin errors++; $display("FAIL all3_points got %h exp %h", d_pts, {3{5'b01000}}); end
    checks++;
    if (d_bases !== {3{32'h0180_0000}}) begin errors++; $display("FAIL all3_bases got %h exp %h", d_bases, {3{32'h0180_0000}}); end
    rd_vs = 3'b000;
    step();
  endtask

  task automatic test_repeat();
    do_reset();
    wr_done_point = 5'b00010; wr_current_point = 5'b00000;
    rd_vs = 3'b010;
    step(); step(); step();
    rd_vs = 3'b000;
    step(); step();
    checks++;
    if (rd1_curr_point !== 5'b00010) begin errors++; $display("FAIL repeat_setup got %b exp %b", rd1_curr_point, 5'b00010); end
    wr_done_point = 5'b10000; wr_current_point = 5'b10000;
    rd_vs = 3'b010;
    step(); step(); step();
    checks++;
    if (rd1_curr_point !== 5'b00010) begin errors++; $display("FAIL repeat_point got %b exp %b", rd1_curr_point, 5'b00010); end
    checks++;
    if (rd1_base_addr !== 32'h0080_0000) begin errors++; $display("FAIL repeat_base got %h exp %h", rd1_base_addr, 32'h0080_0000); end
    checks++;
    if ({rd_repeat, rd_update} !== 6'b010_010) begin errors++; $display("FAIL repeat_pulse got %b exp %b", {rd_repeat, rd_update}, 6'b010_010); end
    rd_vs = 3'b000;
    step(); step();
  endtask

  task automatic test_not_onehot();
    do_reset();
    wr_done_point = 5'b00110; wr_current_point = 5'b00000;
    rd_vs = 3'b100;
    step(); step(); step();
    checks++;
    if (rd2_curr_point !== 5'b00000) begin errors++; $display("FAIL nonone_point got %b exp %b", rd2_curr_point, 5'b00000); end
    checks++;
    if (rd2_base_addr !== BASE) begin errors++; $display("FAIL nonone_base got %h exp %h", rd2_base_addr, BASE); end
    checks++;
    if ({rd_repeat, rd_update} !== 6'b100_100) begin errors++; $display("FAIL nonone_pulse got %b exp %b", {rd_repeat, rd_update}, 6'b100_100); end
    rd_vs = 3'b000;
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_u;
    rd_vs = 3'b000; wr_done_point = 5'b00001; wr_current_point = 5'b00000;
    step(); step();
    rd_vs = 3'b001;
    step();                       // k
    rd_vs = 3'b000;
    step();                       // k+1
    rd_vs = 3'b001;
    for (int s = 2; s <= 6; s++) begin
      step();
      exp_u = (s == 2 || s == 5) ? 3'b001 : 3'b000;
      checks++;
      if (rd_update !== exp_u) begin errors++; $display("FAIL b2b_update_k%0d got %b exp %b", s, rd_update, exp_u); end
    end
    checks++;
    if (d_pts !== e_pts) begin errors++; $display("FAIL b2b_points got %h exp %h", d_pts, e_pts); end
    rd_vs = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    rd_vs = 3'b000; step(); step();
    wr_done_point = 5'b00001; wr_current_point = 5'b00000;
    rd_vs = 3'b010;
    step(); step();               // now in SEL
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp %b", busy, 1'b1); end
    #2;
    wrst_n = 1'b0; rd_vs = 3'b000;
    model_reset();
    #1;
    checks++;
    if (d_pts !== 15'd0) begin errors++; $display("FAIL midrst_points got %h exp %h", d_pts, 15'd0); end
    checks++;
    if (d_bases !== {3{BASE}}) begin errors++; $display("FAIL midrst_bases got %h exp %h", d_bases, {3{BASE}}); end
    checks++;
    if (d_flags !== 7'd0) begin errors++; $display("FAIL midrst_flags got %b exp %b", d_flags, 7'd0); end
    step(); step();
    wrst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      checks++;
      if (d_flags !== 7'd0) begin errors++; $display("FAIL midrst_lost_c%0d got %b exp %b", s, d_flags, 7'd0); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 400; s++) begin
      rd_vs = 3'($urandom_range(0, 7));
      wr_done_point = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : (5'b00001 << $urandom_range(0, 4));
      wr_current_point = 5'b00001 << $urandom_range(0, 4);
      step();
      checks++;
      if (d_pts !== e_pts) begin errors++; $display("FAIL rand_points_c%0d got %h exp %h", s, d_pts, e_pts); end
      checks++;
      if (d_bases !== e_bases) begin errors++; $display("FAIL rand_bases_c%0d got %h exp %h", s, d_bases, e_bases); end
      checks++;
      if (d_flags !== e_flags) begin errors++; $display("FAIL rand_flags_c%0d got %b exp %b", s, d_flags, e_flags); end
    end
    rd_vs = 3'b000;
    step(); step(); step(); step();
  endtask

`ifdef FB_RD_SCHED_STAT_EN
  task automatic test_stat_saturate();
    do_reset();
    wr_done_point = 5'b00000; wr_current_point = 5'b00000;
    for (int s = 0; s < 960; s++) begin
      rd_vs = {2'b00, s[0]};
      step();
    end
    rd_vs = 3'b000;
    step(); step(); step(); step();
    checks++;
    if (m_cnt[0] < 255) begin errors++; $display("FAIL stat_model_repeats got %0d exp %0d", m_cnt[0], 255); end
    checks++;
    if (rd_repeat_cnt !== 24'h0000ff) begin errors++; $display("FAIL stat_saturate got %h exp %h", rd_repeat_cnt, 24'h0000ff); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_repeat();
    test_not_onehot();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef FB_RD_SCHED_STAT_EN
    test_stat_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
